// File: rtl/fios_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | fios_pkg: shared types and constants for the FIOS result path   |
// | Revision: 1.0                                                   |
// +----------------------------------------------------------------+
package fios_pkg;

  localparam int WORD_W = 17;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } coll_state_t;

endpackage
`default_nettype wire

// File: rtl/fios_word_sub.sv
`default_nettype none
// +----------------------------------------------------------------+
// | fios_word_sub: 17-bit subtract-with-borrow slice, borrow flop   |
// | Revision: 1.0                                                   |
// +----------------------------------------------------------------+
module fios_word_sub
  import fios_pkg::*;
(
  input  logic  clock_i,
  input  logic  reset_n_i,
  input  logic  clear_i,
  input  logic  enable_i,
  input  word_t a_i,
  input  word_t b_i,
  output word_t diff_o,
  output logic  borrow_next_o
);

  logic              r_borrow;
  logic [WORD_W:0]   w_d;

  // Bit 17 of the widened difference is the borrow out of this word.
  assign w_d           = {1'b0, a_i} - {1'b0, b_i} - {{WORD_W{1'b0}}, r_borrow};
  assign diff_o        = w_d[WORD_W-1:0];
  assign borrow_next_o = w_d[WORD_W];

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_borrow <= 1'b0;
    end else if (clear_i) begin
      r_borrow <= 1'b0;
    end else if (enable_i) begin
      r_borrow <= w_d[WORD_W];
    end
  end

endmodule
`default_nettype wire

// File: rtl/fios_res_collector.sv
`default_nettype none
// +----------------------------------------------------------------+
// | fios_res_collector: assembles FIOS result words, applies final  |
// | conditional subtraction, offers result over valid/ready.        |
// | Revision: 1.0                                                   |
// +----------------------------------------------------------------+
module fios_res_collector
  import fios_pkg::*;
#(
  parameter int s      = 8,
  parameter int REDUCE = 1
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  start_i,
  input  logic                  res_valid_i,
  input  logic [WORD_W-1:0]     res_word_i,
  input  logic [WORD_W-1:0]     p_word_i,
  output logic [s*WORD_W-1:0]   result_o,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int              CNT_W    = (s > 1) ? $clog2(s) : 1;
  localparam logic [CNT_W-1:0] c_last  = CNT_W'(s - 1);
  localparam bit              c_reduce = (REDUCE != 0);

  coll_state_t          r_state, w_state_next;
  logic [CNT_W-1:0]     r_k;
  logic [s*WORD_W-1:0]  r_raw, r_diff, r_result;
  logic [s*WORD_W-1:0]  w_raw_next, w_diff_next;
  logic                 r_err, w_err, w_accept, w_clear, w_load;
  word_t                w_diff_word;
  logic                 w_borrow_next;

  fios_word_sub u_sub (
    .clock_i       (clock_i),
    .reset_n_i     (reset_n_i),
    .clear_i       (w_clear),
    .enable_i      (w_accept),
    .a_i           (res_word_i),
    .b_i           (p_word_i),
    .diff_o        (w_diff_word),
    .borrow_next_o (w_borrow_next)
  );

  // Stored words plus the word arriving now, so the last word lands in the result directly.
  always_comb begin
    w_raw_next  = r_raw;
    w_diff_next = r_diff;
    w_raw_next[int'(r_k)*WORD_W +: WORD_W]  = res_word_i;
    w_diff_next[int'(r_k)*WORD_W +: WORD_W] = w_diff_word;
  end

  always_comb begin
    w_state_next = r_state;
    w_err        = 1'b0;
    w_accept     = 1'b0;
    w_clear      = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_next = COLLECT;
          w_clear      = 1'b1;
        end else if (res_valid_i) begin
          w_err = 1'b1;
        end
      end
      COLLECT: begin
        if (start_i) begin
          w_err = 1'b1;
        end
        if (res_valid_i) begin
          w_accept = 1'b1;
          if (r_k == c_last) begin
            w_state_next = HOLD;
            w_load       = 1'b1;
          end
        end
      end
      HOLD: begin
        if (res_valid_i) begin
          w_err = 1'b1;
        end
        if (result_ready_i) begin
          if (start_i) begin
            w_state_next = COLLECT;
            w_clear      = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end else if (start_i) begin
          w_err = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_k      <= '0;
      r_raw    <= '0;
      r_diff   <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_err;
      if (w_clear) begin
        r_k <= '0;
      end else if (w_accept) begin
        r_k    <= r_k + 1'b1;
        r_raw  <= w_raw_next;
        r_diff <= w_diff_next;
      end
      if (w_load) begin
        r_result <= (c_reduce && !w_borrow_next) ? w_diff_next : w_raw_next;
      end
    end
  end

  assign result_o       = r_result;
  assign result_valid_o = (r_state == HOLD);
  assign busy_o         = (r_state != IDLE);
  assign err_o          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fios_res_collector.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_fios_res_collector: directed self-checking bench, s=2        |
// | Revision: 1.0                                                   |
// +----------------------------------------------------------------+
module tb_fios_res_collector;

  logic        clock_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic        res_valid_i = 1'b0;
  logic [16:0] res_word_i = '0;
  logic [16:0] p_word_i = '0;
  logic [33:0] result_o;
  logic        result_valid_o;
  logic        result_ready_i = 1'b0;
  logic        busy_o;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [16:0] r0, r1, p0, p1;
    logic [33:0] exp;
  } vec_t;

  vec_t vecs[7];

  fios_res_collector #(.s(2), .REDUCE(1)) dut (
    .clock_i        (clock_i),
    .reset_n_i      (reset_n_i),
    .start_i        (start_i),
    .res_valid_i    (res_valid_i),
    .res_word_i     (res_word_i),
    .p_word_i       (p_word_i),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Start pulse, two words (optional gap), check result at u+1.
  task automatic collect(input vec_t v, input string nm, input bit gap);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk1({nm, " busy"}, busy_o, 1'b1);
    res_valid_i = 1'b1; res_word_i = v.r0; p_word_i = v.p0;
    tick();
    if (gap) begin
      res_valid_i = 1'b0;
      tick();
    end
    chk1({nm, " early_valid"}, result_valid_o, 1'b0);
    res_valid_i = 1'b1; res_word_i = v.r1; p_word_i = v.p1;
    tick();
    res_valid_i = 1'b0;
    chk1({nm, " valid"}, result_valid_o, 1'b1);
    chk({nm, " result"}, result_o, v.exp);
  endtask

  task automatic handshake(input string nm);
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
    chk1({nm, " valid_after_hs"}, result_valid_o, 1'b0);
    chk1({nm, " busy_after_hs"}, busy_o, 1'b0);
  endtask

  initial begin
    vecs[0] = '{r0:17'h00007, r1:17'h00000, p0:17'h00005, p1:17'h00000, exp:34'h0_0000_0002};
    vecs[1] = '{r0:17'h00003, r1:17'h00000, p0:17'h00005, p1:17'h00000, exp:34'h0_0000_0003};
    vecs[2] = '{r0:17'h1ABCD, r1:17'h00012, p0:17'h1ABCD, p1:17'h00012, exp:34'h0_0000_0000};
    vecs[3] = '{r0:17'h00000, r1:17'h00002, p0:17'h00001, p1:17'h00001, exp:34'h0_0001_FFFF};
    vecs[4] = '{r0:17'h10000, r1:17'h00003, p0:17'h10001, p1:17'h00001, exp:34'h0_0003_FFFF};
    vecs[5] = '{r0:17'h1FFFF, r1:17'h00000, p0:17'h00000, p1:17'h00001, exp:34'h0_0001_FFFF};
    vecs[6] = '{r0:17'h1FFFF, r1:17'h00001, p0:17'h00010, p1:17'h00001, exp:34'h0_0001_FFEF};

    tick();
    tick();
    chk("rst result", result_o, 34'h0);
    chk1("rst valid", result_valid_o, 1'b0);
    chk1("rst busy", busy_o, 1'b0);
    chk1("rst err", err_o, 1'b0);
    reset_n_i = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      collect(vecs[i], $sformatf("vec%0d", i), 1'b0);
      handshake($sformatf("vec%0d", i));
    end

    // Backpressure with a gap between words.
    collect(vecs[0], "bp", 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp hold result", result_o, 34'h2);
      chk1("bp hold valid", result_valid_o, 1'b1);
    end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk1("bp start err", err_o, 1'b1);
    chk1("bp still hold", result_valid_o, 1'b1);
    tick();
    chk1("bp err one cycle", err_o, 1'b0);
    res_valid_i = 1'b1; res_word_i = 17'h00055; p_word_i = 17'h0;
    tick();
    res_valid_i = 1'b0;
    chk1("hold word err", err_o, 1'b1);
    chk("hold word dropped", result_o, 34'h2);

    // Restart in the handshake cycle goes straight back to COLLECT.
    start_i = 1'b1; result_ready_i = 1'b1;
    tick();
    start_i = 1'b0; result_ready_i = 1'b0;
    chk1("restart valid", result_valid_o, 1'b0);
    chk1("restart busy", busy_o, 1'b1);
    chk1("restart err", err_o, 1'b0);
    res_valid_i = 1'b1; res_word_i = vecs[3].r0; p_word_i = vecs[3].p0;
    tick();
    res_word_i = vecs[3].r1; p_word_i = vecs[3].p1;
    tick();
    res_valid_i = 1'b0;
    chk1("restart result valid", result_valid_o, 1'b1);
    chk("restart result", result_o, vecs[3].exp);
    handshake("restart");

    // Stray word in IDLE.
    res_valid_i = 1'b1;
    tick();
    res_valid_i = 1'b0;
    chk1("idle word err", err_o, 1'b1);
    chk1("idle word busy", busy_o, 1'b0);
    tick();
    chk1("idle err one cycle", err_o, 1'b0);

    // Asynchronous reset after the first word.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    res_valid_i = 1'b1; res_word_i = 17'h00009; p_word_i = 17'h00005;
    tick();
    res_valid_i = 1'b0;
    #1;
    reset_n_i = 1'b0;
    #1;
    chk("async rst result", result_o, 34'h0);
    chk1("async rst valid", result_valid_o, 1'b0);
    chk1("async rst busy", busy_o, 1'b0);
    chk1("async rst err", err_o, 1'b0);
    tick();
    reset_n_i = 1'b1;
    tick();
    collect(vecs[0], "post rst", 1'b0);
    handshake("post rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
